// File: rtl/act_sched.sv
// act_sched: round-robin scheduler sharing one combinational sigmoid unit
// between N LSTM gate requesters. One registered issue stage (s1) feeds the
// shared unit; results return through per-requester holding registers.
// Optional feature macro: ACT_SCHED_PERF_EN adds a saturating op_count port.

// Per-requester result holding register with valid/ready drain
module act_sched_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       rd,
  output logic       vld,
  output logic [7:0] dout
);
  // A landing result wins over a same-edge drain so no result is lost
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld  <= 1'b0;
      dout <= '0;
    end else if (wr) begin
      vld  <= 1'b1;
      dout <= din;
    end else if (rd) begin
      vld  <= 1'b0;
    end
  end
endmodule

module act_sched #(
  parameter int N  = 4,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [8*N-1:0] req_z,
  output logic [N-1:0]   rsp_valid,
  input  logic [N-1:0]   rsp_ready,
  output logic [8*N-1:0] rsp_a,
  output logic [7:0]     fu_z,
  input  logic [7:0]     fu_a,
  output logic           busy
`ifdef ACT_SCHED_PERF_EN
  ,
  output logic [CW-1:0]  op_count
`endif
);
  localparam int TW = $clog2(N);

  logic [N-1:0][7:0] z_arr;
  logic [N-1:0][7:0] a_arr;
  logic              s1_valid;
  logic [TW-1:0]     s1_tag;
  logic [TW-1:0]     last;
  logic [TW-1:0]     gnt_idx;
  logic [N-1:0]      elig;
  logic [N-1:0]      gnt;
  logic [N-1:0]      wr;
  logic              found;
  logic [TW:0]       cand;

  assign z_arr     = req_z;
  assign rsp_a     = a_arr;
  assign req_ready = gnt;
  assign busy      = s1_valid | (|rsp_valid);

  for (genvar i = 0; i < N; i++) begin : g_lane
    // wr doubles as "op for i in flight": a lane with an op in s1 is not eligible
    assign wr[i]   = s1_valid && (s1_tag == TW'(i));
    assign elig[i] = req_valid[i] && !wr[i] && (!rsp_valid[i] || rsp_ready[i]);

    act_sched_lane u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .wr   (wr[i]),
      .din  (fu_a),
      .rd   (rsp_ready[i]),
      .vld  (rsp_valid[i]),
      .dout (a_arr[i])
    );
  end

  // Round-robin search starting one past the last grant; first eligible wins
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + (TW+1)'(k);
      if (cand >= (TW+1)'(N)) cand = cand - (TW+1)'(N);
      if (!found && elig[cand[TW-1:0]]) begin
        found                = 1'b1;
        gnt[cand[TW-1:0]]    = 1'b1;
        gnt_idx              = cand[TW-1:0];
      end
    end
  end

  // Issue stage: capture the granted operand; fu_z holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      fu_z     <= '0;
      last     <= TW'(N-1);
    end else if (found) begin
      s1_valid <= 1'b1;
      s1_tag   <= gnt_idx;
      fu_z     <= z_arr[gnt_idx];
      last     <= gnt_idx;
    end else begin
      s1_valid <= 1'b0;
    end
  end

`ifdef ACT_SCHED_PERF_EN
  // Count holding-register writes, sticking at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         op_count <= '0;
    else if (s1_valid && !(&op_count))  op_count <= op_count + CW'(1);
  end
`endif

endmodule

// File: tb/tb_act_sched.sv
// tb_act_sched: randomized and directed bench for act_sched against a
// behavioural model of the scheduler rules. Shared unit modelled as z ^ 8'h5A.
module tb_act_sched;
  localparam int N = 4;
`ifdef ACT_SCHED_PERF_EN
  localparam int CW = 4;
`else
  localparam int CW = 16;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [8*N-1:0] req_z, rsp_a;
  logic [7:0]     fu_z, fu_a;
  logic           busy;
`ifdef ACT_SCHED_PERF_EN
  logic [CW-1:0]  op_count;
`endif

  int total = 0;
  int bad   = 0;

  // model state
  logic              m_s1v;
  int                m_tag;
  logic [7:0]        m_fuz;
  int                m_last;
  logic [N-1:0]      m_hv;
  logic [N-1:0][7:0] m_ha;
  int                m_cnt;

  logic [N-1:0]      seen;

  always #5 clk = ~clk;
  assign fu_a = fu_z ^ 8'h5A;

  act_sched #(.N(N), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_z    (req_z),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_a    (rsp_a),
    .fu_z     (fu_z),
    .fu_a     (fu_a),
    .busy     (busy)
`ifdef ACT_SCHED_PERF_EN
    ,
    .op_count (op_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_s1v  = 1'b0;
    m_tag  = 0;
    m_fuz  = 8'h00;
    m_last = N - 1;
    m_hv   = '0;
    m_ha   = '0;
    m_cnt  = 0;
  endfunction

  // Who should be granted now, from the eligibility rule and rotating priority
  function automatic int model_grant();
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_last + k) % N;
      if (req_valid[i] && !(m_s1v && m_tag == i) && (!m_hv[i] || rsp_ready[i]))
        return i;
    end
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd0);
    chk({tag, "_fuz"}, 32'(fu_z), 32'd0);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_a"},   32'(rsp_a), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef ACT_SCHED_PERF_EN
    chk({tag, "_cnt"}, 32'(op_count), 32'd0);
`endif
  endtask

  // One cycle: drive at negedge, check against the model, advance the model at posedge
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] rr,
                      input logic [8*N-1:0] z, output logic [N-1:0] got_rdy);
    int g;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    req_valid = v;
    rsp_ready = rr;
    req_z     = z;
    #1;
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    got_rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("fu_z", 32'(fu_z), 32'(m_fuz));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_hv));
    chk("rsp_a", 32'(rsp_a), 32'(m_ha));
    chk("busy", 32'(busy), 32'(m_s1v | (|m_hv)));
`ifdef ACT_SCHED_PERF_EN
    chk("op_count", 32'(op_count), 32'(m_cnt));
`endif
    @(posedge clk);
    if (m_s1v) begin
      m_hv[m_tag] = 1'b1;
      m_ha[m_tag] = m_fuz ^ 8'h5A;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end
    for (int i = 0; i < N; i++)
      if (rsp_ready[i] && !(m_s1v && m_tag == i)) m_hv[i] = 1'b0;
    if (g >= 0) begin
      m_s1v  = 1'b1;
      m_tag  = g;
      m_fuz  = req_z[8*g +: 8];
      m_last = g;
    end else begin
      m_s1v = 1'b0;
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    #1;
    model_reset();
    check_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_z     = '0;
    model_reset();
    #12;
    check_zero("por");
    @(negedge clk);
    rst_n = 1'b1;

    // single request from requester 0
    step(4'b0001, 4'b0000, 32'h0000_0010, seen);
    chk("single_rdy", 32'(seen), 32'h1);
    #1 chk("single_fuz", 32'(fu_z), 32'h10);
    step(4'b0000, 4'b0000, 32'h0, seen);
    #1;
    chk("single_vld", 32'(rsp_valid[0]), 32'h1);
    chk("single_a", 32'(rsp_a[7:0]), 32'h4A);
`ifdef ACT_SCHED_PERF_EN
    chk("single_cnt", 32'(op_count), 32'h1);
`endif
    step(4'b0000, 4'b1111, 32'h0, seen);

    // fairness: everyone always valid, always draining
    do_reset("fair_rst");
    for (int c = 0; c < 12; c++) begin
      step(4'b1111, 4'b1111, 32'h0403_0201, seen);
      chk("fair_gnt", 32'(seen), 32'(1 << (c % 4)));
    end
    #1;
    for (int i = 0; i < N; i++)
      chk("fair_a", 32'(rsp_a[8*i +: 8]), 32'((i + 1) ^ 8'h5A));

    // backpressure on requester 2
    do_reset("bp_rst");
    step(4'b0100, 4'b0000, 32'h00AB_0000, seen);
    step(4'b0000, 4'b0000, 32'h0, seen);
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, 4'b1011, 32'h4433_2211, seen);
      chk("bp_skip2", 32'(seen[2]), 32'h0);
      chk("bp_served", 32'(|seen), 32'h1);
    end
    step(4'b0100, 4'b0100, 32'h0077_0000, seen);
    chk("bp_release", 32'(seen), 32'b0100);
    step(4'b0000, 4'b1111, 32'h0, seen);
    step(4'b0000, 4'b1111, 32'h0, seen);

    // drain and refill on requester 1 with rsp_ready held high
    do_reset("dr_rst");
    step(4'b0010, 4'b0010, 32'h0000_3300, seen);
    step(4'b0000, 4'b0010, 32'h0, seen);
    #1;
    chk("dr_vld0", 32'(rsp_valid[1]), 32'h1);
    chk("dr_a0", 32'(rsp_a[15:8]), 32'(8'h33 ^ 8'h5A));
    step(4'b0010, 4'b0010, 32'h0000_C600, seen);
    step(4'b0000, 4'b0010, 32'h0, seen);
    #1;
    chk("dr_vld1", 32'(rsp_valid[1]), 32'h1);
    chk("dr_a1", 32'(rsp_a[15:8]), 32'(8'hC6 ^ 8'h5A));

    // reset in the cycle after a grant
    do_reset("mid_pre");
    step(4'b0001, 4'b0000, 32'h0000_0055, seen);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = '0;
    #1;
    model_reset();
    check_zero("mid_async");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) step(4'b0000, 4'b0000, 32'h0, seen);
    step(4'b1111, 4'b0000, 32'h8877_6655, seen);
    chk("mid_first", 32'(seen), 32'h1);

`ifdef ACT_SCHED_PERF_EN
    // counter saturation
    do_reset("sat_rst");
    for (int c = 0; c < 22; c++) step(4'b1111, 4'b1111, 32'h1234_5678, seen);
    #1 chk("sat_cnt", 32'(op_count), 32'hF);
`endif

    // random traffic
    do_reset("rnd_rst");
    for (int c = 0; c < 400; c++)
      step(N'($urandom), N'($urandom | $urandom), 32'($urandom), seen);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
